hazard_field_ctrl: RTL and testbench
====================================

// Module: hazard_field_ctrl
// PURPOSE
//  Parametrised controller for OBJ_CNT falling hazard sprites plus game state (IDLE/PLAY/DEAD).
//  Replaces hand-unrolled per-meteor position/score/collision logic in top-level game files.
//  Owns the spawn LFSR and per-frame object motion, and latches player collisions.
//  Outputs object coordinates to sprite instances and a score to the BCD/seven-segment path.
// PARAMETERS
//  OBJ_CNT    5             number of hazard objects (1..16)
//  CORDW      16            signed coordinate width
//  LFSR_W     9             spawn LFSR width
//  LFSR_TAPS  9'b101110010  Galois feedback mask (right-shift)
//  X_BASE     158           IDLE x of object 0
//  X_STEP     64            IDLE x spacing, also respawn x offset per object
//  SPAWN_Y    -300          respawn y (signed)
//  Y_STAGGER  100           IDLE y of object i = SPAWN_Y - i*Y_STAGGER
//  GROUND_Y   230           object respawns when y > GROUND_Y
//  FALL_SPD   2             pixels per frame
//  SCORE_W    8             score width
// PORTS
//  clk_pix    in   1               pixel clock
//  rst_n      in   1               async active-low reset
//  frame      in   1               1-cycle pulse, start of frame
//  de         in   1               display enable (LFSR advance strobe)
//  start      in   1               debounced start/restart level or pulse
//  hit        in   OBJ_CNT         per-object collision with player; transparency already applied and aligned
//  obj_x      out  OBJ_CNT*CORDW   packed signed x; object i at [i*CORDW +: CORDW]
//  obj_y      out  OBJ_CNT*CORDW   packed signed y, same packing
//  score      out  SCORE_W         objects dodged; saturates
//  state      out  2               0 IDLE, 1 PLAY, 2 DEAD
//  dead       out  1               state==DEAD
//  lfsr       out  LFSR_W          current LFSR value (debug)
// BEHAVIOUR
//  Reset (async assert, sync release):
//   state=IDLE; score=0; lfsr=all ones; obj_x[i]=X_BASE+i*X_STEP; obj_y[i]=SPAWN_Y-i*Y_STAGGER.
//  LFSR:
//   On every de cycle, in every state: lfsr <= (lfsr>>1) ^ (lfsr[0] ? LFSR_TAPS : 0).
//   If lfsr==0, reload all ones on the next cycle (lockup guard).
//  IDLE:
//   Objects held at reset positions; score held at 0.
//   start=1 -> PLAY on the next clk_pix edge.
//  PLAY, on each frame pulse, per object i independently:
//   - if obj_y[i] > GROUND_Y (signed compare): obj_y[i]<=SPAWN_Y;
//     obj_x[i] <= zero-extended (lfsr + i*X_STEP) mod 2^LFSR_W; object counts as landed.
//   - else obj_y[i] <= obj_y[i] + speed.
//  Score:
//   score <= min(score + popcount(landed), 2^SCORE_W-1), computed in the same cycle as the respawn.
//   Simultaneous landings all count.
//  Collision:
//   Any hit bit while state==PLAY -> DEAD on the next edge, one-cycle latency; sampled every cycle.
//   If hit coincides with frame, the motion for that frame still applies and the state becomes DEAD.
//   hit is ignored in IDLE and DEAD.
//  DEAD:
//   Objects and score frozen.
//   start=1 -> IDLE: positions restored; score cleared on entry to IDLE.
//   start must deassert, then reassert, before IDLE -> PLAY (edge-qualified restart) so that a held button cannot skip IDLE.
//  Arithmetic:
//   Coordinates are signed CORDW with no wrap protection; the parameters must keep SPAWN_Y-OBJ_CNT*Y_STAGGER in range.
//  Reset mid-operation returns everything to the reset values immediately.
// CONFIGURATION
//  HAZARD_SPEEDUP_EN defined:
//   speed = FALL_SPD + min(score>>3, 6); recomputed from the registered score; takes effect at the next frame.
//  Not defined:
//   speed = FALL_SPD constant; the speedup logic is absent.
// TESTING
//  1. Reset, no start, 10 frames -> state=0; obj_y[0]=-300; obj_y[4]=-700; obj_x[2]=286; score=0.
//  2. start; 1 frame -> state=1; obj_y[0]=-298. Run until obj_y[0]=232 at a frame ->
//     next frame obj_y[0]=-300, obj_x[0]=lfsr value sampled at that edge, score=1.
//  3. Force two objects to y=231, pulse frame -> both respawn, score +2.
//     Preload score=254 -> score=255, stays 255.
//  4. PLAY, hit=5'b00100 for 1 cycle -> dead=1 next cycle; 3 frames -> obj_y/score unchanged.
//     Hold start -> state=0, score=0, stays IDLE until start is released and pressed again.
//  5. Assert rst_n=0 mid-PLAY without a clock edge -> all outputs at reset values immediately; lfsr=9'h1FF.
//  6. HAZARD_SPEEDUP_EN: score=16 -> per-frame y step=4; score>=48 -> step=8 (FALL_SPD+6).

Source files
------------

// File: rtl/hazard_field_ctrl_if.sv
// Bus between the hazard field controller and the game top: frame/input strobes in,
// object coordinates, score, game state and LFSR debug value out.
interface hazard_field_ctrl_if #(
    parameter int unsigned OBJ_CNT = 5,
    parameter int unsigned CORDW   = 16,
    parameter int unsigned LFSR_W  = 9,
    parameter int unsigned SCORE_W = 8
);
    logic                       frame;
    logic                       de;
    logic                       start;
    logic [OBJ_CNT-1:0]         hit;
    logic [OBJ_CNT*CORDW-1:0]   obj_x;
    logic [OBJ_CNT*CORDW-1:0]   obj_y;
    logic [SCORE_W-1:0]         score;
    logic [1:0]                 state;
    logic                       dead;
    logic [LFSR_W-1:0]          lfsr;

    // Game top / stimulus side
    modport master (
        output frame, de, start, hit,
        input  obj_x, obj_y, score, state, dead, lfsr
    );

    // Controller side
    modport slave (
        input  frame, de, start, hit,
        output obj_x, obj_y, score, state, dead, lfsr
    );
endinterface

// File: rtl/hazard_field_ctrl.sv
// Falling-hazard field controller: spawn LFSR, per-frame object motion, scoring and IDLE/PLAY/DEAD game state.
// Optional macro HAZARD_SPEEDUP_EN: fall speed grows with score (FALL_SPD + min(score>>3, 6)).
module hazard_field_ctrl #(
    parameter int unsigned       OBJ_CNT   = 5,
    parameter int unsigned       CORDW     = 16,
    parameter int unsigned       LFSR_W    = 9,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = 9'b101110010,
    parameter int                X_BASE    = 158,
    parameter int                X_STEP    = 64,
    parameter int                SPAWN_Y   = -300,
    parameter int                Y_STAGGER = 100,
    parameter int                GROUND_Y  = 230,
    parameter int                FALL_SPD  = 2,
    parameter int unsigned       SCORE_W   = 8
) (
    input  logic                clk_pix,
    input  logic                rst_n,
    hazard_field_ctrl_if.slave  bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_DEAD = 2'd2;

    localparam int unsigned POS_W = OBJ_CNT * CORDW;
    localparam int unsigned CNT_W = $clog2(OBJ_CNT + 1);
    localparam int unsigned SUM_W = SCORE_W + CNT_W;

    localparam logic [SCORE_W-1:0]      SCORE_MAX = '1;
    localparam logic signed [CORDW-1:0] GROUND_C  = CORDW'(GROUND_Y);
    localparam logic [CORDW-1:0]        SPAWN_C   = CORDW'(SPAWN_Y);

    // Home (IDLE) coordinates, packed the same way as the outputs
    function automatic logic [POS_W-1:0] home_x();
        logic [POS_W-1:0] v;
        v = '0;
        for (int i = 0; i < int'(OBJ_CNT); i++)
            v[i*CORDW +: CORDW] = CORDW'(X_BASE + i * X_STEP);
        return v;
    endfunction

    function automatic logic [POS_W-1:0] home_y();
        logic [POS_W-1:0] v;
        v = '0;
        for (int i = 0; i < int'(OBJ_CNT); i++)
            v[i*CORDW +: CORDW] = CORDW'(SPAWN_Y - i * Y_STAGGER);
        return v;
    endfunction

    localparam logic [POS_W-1:0] X_INIT = home_x();
    localparam logic [POS_W-1:0] Y_INIT = home_y();

    logic [1:0]          state_q, state_nx;
    logic                dead_q;
    logic                armed_q, armed_nx;
    logic [SCORE_W-1:0]  score_q, score_nx;
    logic [LFSR_W-1:0]   lfsr_q, lfsr_nx;
    logic [POS_W-1:0]    obj_x_q, obj_x_nx;
    logic [POS_W-1:0]    obj_y_q, obj_y_nx;

    logic [CORDW-1:0]        speed;
    logic signed [CORDW-1:0] y_cur;
    logic [LFSR_W-1:0]       x_raw;
    logic [OBJ_CNT-1:0]      landed;
    logic [CNT_W-1:0]        landed_cnt;
    logic [SUM_W-1:0]        score_sum;

`ifdef HAZARD_SPEEDUP_EN
    logic [SCORE_W-1:0] level;

    // Speed bonus from the registered score, capped at +6
    always_comb begin
        level = score_q >> 3;
        if (level > SCORE_W'(6))
            speed = CORDW'(FALL_SPD + 6);
        else
            speed = CORDW'(FALL_SPD) + CORDW'(level);
    end
`else
    assign speed = CORDW'(FALL_SPD);
`endif

    // Next-state: LFSR, game FSM, object motion and scoring
    always_comb begin
        state_nx   = state_q;
        armed_nx   = armed_q;
        score_nx   = score_q;
        lfsr_nx    = lfsr_q;
        obj_x_nx   = obj_x_q;
        obj_y_nx   = obj_y_q;
        y_cur      = '0;
        x_raw      = '0;
        landed     = '0;
        landed_cnt = '0;
        score_sum  = '0;

        if (lfsr_q == '0)
            lfsr_nx = '1;
        else if (bus.de)
            lfsr_nx = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);

        // A restart press only counts once start has been seen low
        if (!bus.start)
            armed_nx = 1'b1;

        case (state_q)
            ST_IDLE: begin
                obj_x_nx = X_INIT;
                obj_y_nx = Y_INIT;
                score_nx = '0;
                if (bus.start && armed_q)
                    state_nx = ST_PLAY;
            end

            ST_PLAY: begin
                if (bus.frame) begin
                    for (int i = 0; i < int'(OBJ_CNT); i++) begin
                        y_cur = $signed(obj_y_q[i*CORDW +: CORDW]);
                        if (y_cur > GROUND_C) begin
                            x_raw = lfsr_q + LFSR_W'(i * X_STEP);
                            obj_y_nx[i*CORDW +: CORDW] = SPAWN_C;
                            obj_x_nx[i*CORDW +: CORDW] = CORDW'(x_raw);
                            landed[i] = 1'b1;
                        end else begin
                            obj_y_nx[i*CORDW +: CORDW] = y_cur + speed;
                        end
                    end
                    for (int i = 0; i < int'(OBJ_CNT); i++)
                        landed_cnt = landed_cnt + CNT_W'(landed[i]);
                    score_sum = SUM_W'(score_q) + SUM_W'(landed_cnt);
                    if (score_sum > SUM_W'(SCORE_MAX))
                        score_nx = SCORE_MAX;
                    else
                        score_nx = score_sum[SCORE_W-1:0];
                end
                if (|bus.hit)
                    state_nx = ST_DEAD;
            end

            ST_DEAD: begin
                if (bus.start) begin
                    state_nx = ST_IDLE;
                    armed_nx = 1'b0;
                    obj_x_nx = X_INIT;
                    obj_y_nx = Y_INIT;
                    score_nx = '0;
                end
            end

            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            dead_q  <= 1'b0;
            armed_q <= 1'b1;
            score_q <= '0;
            lfsr_q  <= '1;
            obj_x_q <= X_INIT;
            obj_y_q <= Y_INIT;
        end else begin
            state_q <= state_nx;
            dead_q  <= (state_nx == ST_DEAD);
            armed_q <= armed_nx;
            score_q <= score_nx;
            lfsr_q  <= lfsr_nx;
            obj_x_q <= obj_x_nx;
            obj_y_q <= obj_y_nx;
        end
    end

    assign bus.obj_x = obj_x_q;
    assign bus.obj_y = obj_y_q;
    assign bus.score = score_q;
    assign bus.state = state_q;
    assign bus.dead  = dead_q;
    assign bus.lfsr  = lfsr_q;
endmodule

// File: tb/tb_hazard_field_ctrl.sv
// Bench for hazard_field_ctrl: two instances (staggered and unstaggered objects) driven by shared
// randomized stimulus and checked every cycle against a behavioural game model.
module tb_hazard_field_ctrl;
    localparam int OBJ = 5;
    localparam int CW  = 16;

    logic           clk_pix = 1'b0;
    logic           rst_n;
    logic           frame, de, start;
    logic [OBJ-1:0] hit;

    int checks   = 0;
    int failures = 0;

    // Model: game state, lfsr, restart arming, per-instance score and coordinates
    int m_state;
    int m_lfsr;
    bit m_armed;
    int m_score[2];
    int m_x[2][OBJ];
    int m_y[2][OBJ];

    always #5 clk_pix = ~clk_pix;

    hazard_field_ctrl_if #(.OBJ_CNT(OBJ), .CORDW(CW), .LFSR_W(9), .SCORE_W(8)) bus_a ();
    hazard_field_ctrl_if #(.OBJ_CNT(OBJ), .CORDW(CW), .LFSR_W(9), .SCORE_W(8)) bus_z ();

    assign bus_a.frame = frame;
    assign bus_a.de    = de;
    assign bus_a.start = start;
    assign bus_a.hit   = hit;
    assign bus_z.frame = frame;
    assign bus_z.de    = de;
    assign bus_z.start = start;
    assign bus_z.hit   = hit;

    hazard_field_ctrl dut_a (.clk_pix(clk_pix), .rst_n(rst_n), .bus(bus_a));
    hazard_field_ctrl #(.Y_STAGGER(0)) dut_z (.clk_pix(clk_pix), .rst_n(rst_n), .bus(bus_z));

    function automatic int stagger(int k);
        return (k == 0) ? 100 : 0;
    endfunction

    function automatic int speed(int sc);
`ifdef HAZARD_SPEEDUP_EN
        return 2 + (((sc >> 3) > 6) ? 6 : (sc >> 3));
`else
        return 2 + 0 * sc;
`endif
    endfunction

    function automatic int field(logic [OBJ*CW-1:0] v, int i);
        logic signed [CW-1:0] t;
        t = v[i*CW +: CW];
        return int'(t);
    endfunction

    task automatic model_home(int k);
        for (int i = 0; i < OBJ; i++) begin
            m_x[k][i] = 158 + i * 64;
            m_y[k][i] = -300 - i * stagger(k);
        end
        m_score[k] = 0;
    endtask

    task automatic model_reset();
        m_state = 0;
        m_lfsr  = 'h1FF;
        m_armed = 1'b1;
        model_home(0);
        model_home(1);
    endtask

    // One clock edge of the game, from the inputs present at that edge
    task automatic model_step();
        int ns, nl, n;
        nl = m_lfsr;
        if (m_lfsr == 0) nl = 'h1FF;
        else if (de) nl = (m_lfsr >> 1) ^ (((m_lfsr & 1) != 0) ? 'h172 : 0);
        ns = m_state;
        if (m_state == 0 && start && m_armed) ns = 1;
        else if (m_state == 1 && hit != '0) ns = 2;
        else if (m_state == 2 && start) ns = 0;
        if (m_state == 1 && frame) begin
            for (int k = 0; k < 2; k++) begin
                n = 0;
                for (int i = 0; i < OBJ; i++) begin
                    if (m_y[k][i] > 230) begin
                        m_y[k][i] = -300;
                        m_x[k][i] = (m_lfsr + i * 64) % 512;
                        n++;
                    end else begin
                        m_y[k][i] = m_y[k][i] + speed(m_score[k]);
                    end
                end
                m_score[k] = (m_score[k] + n > 255) ? 255 : m_score[k] + n;
            end
        end
        if (m_state == 2 && ns == 0) begin
            model_home(0);
            model_home(1);
        end
        if (!start) m_armed = 1'b1;
        else if (m_state == 2 && ns == 0) m_armed = 1'b0;
        m_state = ns;
        m_lfsr  = nl;
    endtask

    task automatic check(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("state_a", int'(bus_a.state), m_state);
        check("state_z", int'(bus_z.state), m_state);
        check("dead_a", int'(bus_a.dead), (m_state == 2) ? 1 : 0);
        check("dead_z", int'(bus_z.dead), (m_state == 2) ? 1 : 0);
        check("lfsr_a", int'(bus_a.lfsr), m_lfsr);
        check("lfsr_z", int'(bus_z.lfsr), m_lfsr);
        check("score_a", int'(bus_a.score), m_score[0]);
        check("score_z", int'(bus_z.score), m_score[1]);
        for (int i = 0; i < OBJ; i++) begin
            check($sformatf("x_a%0d", i), field(bus_a.obj_x, i), m_x[0][i]);
            check($sformatf("y_a%0d", i), field(bus_a.obj_y, i), m_y[0][i]);
            check($sformatf("x_z%0d", i), field(bus_z.obj_x, i), m_x[1][i]);
            check($sformatf("y_z%0d", i), field(bus_z.obj_y, i), m_y[1][i]);
        end
    endtask

    // Apply inputs, take one edge, then compare 1 time unit after it
    task automatic cyc(bit f, bit s, logic [OBJ-1:0] h);
        frame = f;
        start = s;
        hit   = h;
        de    = 1'($urandom_range(0, 1));
        @(posedge clk_pix);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic run_frames(int n);
        for (int j = 0; j < n; j++) cyc(1'b1, 1'b0, '0);
    endtask

    initial begin
        int lf;
        rst_n = 1'b0;
        frame = 1'b0;
        de    = 1'b0;
        start = 1'b0;
        hit   = '0;
        model_reset();
        #12;
        compare_all();
        check("lit_rst_lfsr", int'(bus_a.lfsr), 'h1FF);
        rst_n = 1'b1;

        // IDLE: frames and hits have no effect
        for (int j = 0; j < 10; j++) cyc(1'b1, 1'b0, OBJ'($urandom_range(0, 31)));
        check("lit_idle_state", int'(bus_a.state), 0);
        check("lit_idle_y0", field(bus_a.obj_y, 0), -300);
        check("lit_idle_y4", field(bus_a.obj_y, 4), -700);
        check("lit_idle_x2", field(bus_a.obj_x, 2), 286);
        check("lit_idle_score", int'(bus_a.score), 0);

        cyc(1'b0, 1'b1, '0);
        check("lit_play_state", int'(bus_a.state), 1);
        cyc(1'b1, 1'b0, '0);
        check("lit_first_y0", field(bus_a.obj_y, 0), -298);

        // Object 0 reaches 232 after 266 frames and respawns on the next one
        run_frames(265);
        check("lit_y0_232", field(bus_a.obj_y, 0), 232);
        lf = m_lfsr;
        cyc(1'b1, 1'b0, '0);
        check("lit_respawn_y0", field(bus_a.obj_y, 0), -300);
        check("lit_respawn_x0", field(bus_a.obj_x, 0), lf);
        check("lit_score_1", int'(bus_a.score), 1);
        check("lit_simul_5", int'(bus_z.score), 5);

        // Long run to saturate both scores
        run_frames(14400);
        check("lit_sat_a", int'(bus_a.score), 255);
        check("lit_sat_z", int'(bus_z.score), 255);

        // Hit together with a frame: motion applies, then DEAD freezes everything
        cyc(1'b1, 1'b0, 5'b00100);
        check("lit_dead", int'(bus_a.dead), 1);
        for (int j = 0; j < 3; j++) cyc(1'b1, 1'b0, OBJ'($urandom_range(0, 31)));
        check("lit_dead_score", int'(bus_a.score), 255);
        check("lit_dead_state", int'(bus_a.state), 2);

        // Held start returns to IDLE but cannot re-enter PLAY until released
        cyc(1'b0, 1'b1, '0);
        check("lit_restart_idle", int'(bus_a.state), 0);
        check("lit_restart_score", int'(bus_a.score), 0);
        for (int j = 0; j < 5; j++) cyc(1'b1, 1'b1, '0);
        check("lit_held_idle", int'(bus_a.state), 0);
        cyc(1'b0, 1'b0, '0);
        cyc(1'b0, 1'b1, '0);
        check("lit_repress_play", int'(bus_a.state), 1);

        // Randomized play
        for (int j = 0; j < 3000; j++)
            cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 31) == 0) ? OBJ'($urandom_range(1, 31)) : '0);

        // Get into PLAY from any state, then reset asynchronously mid-cycle
        cyc(1'b0, 1'b0, '0);
        cyc(1'b0, 1'b1, '0);
        cyc(1'b0, 1'b0, '0);
        cyc(1'b0, 1'b1, '0);
        run_frames(20);
        check("lit_pre_rst_play", int'(bus_a.state), 1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("lit_async_lfsr", int'(bus_a.lfsr), 'h1FF);
        check("lit_async_y4", field(bus_a.obj_y, 4), -700);
        #3;
        rst_n = 1'b1;
        for (int j = 0; j < 5; j++) cyc(1'b1, 1'b0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
